// File: rtl/heater_pkg.sv
// Shared types and widths for the heater soft-start sequencer and its helpers.
package heater_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    STEP   = 3'd1,
    STEADY = 3'd2,
    FAULT  = 3'd3,
    CLEAR  = 3'd4
  } state_e;

  localparam int NCHAN_DEF = 32;
  localparam int STEP_W    = 16;
endpackage

// File: rtl/heater_prio_enc.sv
// Priority encoder returning the lowest (or, with FIND_HIGH, the highest) set bit index.
module heater_prio_enc #(
  parameter int W         = 32,
  parameter bit FIND_HIGH = 1'b0
) (
  input  logic [W-1:0]         vec,
  output logic [$clog2(W)-1:0] idx,
  output logic                 valid
);
  localparam int IW = $clog2(W);

  always_comb begin
    idx   = '0;
    valid = |vec;
    if (FIND_HIGH) begin
      for (int i = 0; i < W; i++) begin
        if (vec[i]) idx = IW'(i);
      end
    end else begin
      for (int i = W - 1; i >= 0; i--) begin
        if (vec[i]) idx = IW'(i);
      end
    end
  end
endmodule

// File: rtl/heater_ramp_ctrl.sv
// Soft-start sequencer: ramps heater enables one channel per step interval and
// supervises heater errors, shutting all channels down and sequencing recovery.
module heater_ramp_ctrl
  import heater_pkg::*;
#(
  parameter int Nchan = NCHAN_DEF,
  parameter int Nclr  = 4
) (
  input  logic                     clk,
  input  logic                     aresetn,
  input  logic [Nchan-1:0]         target_mask,
  input  logic [STEP_W-1:0]        step_interval,
  input  logic                     fault_en,
  input  logic                     clear_req,
  input  logic [Nchan-1:0]         heater_error,
  output logic [Nchan-1:0]         heater_enable,
  output logic [Nchan-1:0]         heater_err_clear,
  output logic                     busy,
  output logic                     fault,
  output logic [Nchan-1:0]         fault_mask,
  output logic [$clog2(Nchan)-1:0] fault_chan,
  output logic [Nchan-1:0]         err_sticky
);
  localparam int CW = $clog2(Nchan);
  localparam int KW = $clog2(Nclr + 1);
  localparam logic [Nchan-1:0] ONE = {{(Nchan-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [Nchan-1:0]    tgt_q;
  logic [Nchan-1:0]    en_q, en_d;
  logic [Nchan-1:0]    clr_q, clr_d;
  logic [Nchan-1:0]    mask_q, mask_d;
  logic [CW-1:0]       chan_q, chan_d;
  logic [Nchan-1:0]    sticky_q, sticky_d;
  logic [STEP_W-1:0]   timer_q, timer_d;
  logic [KW-1:0]       cnt_q, cnt_d;

  logic [Nchan-1:0]    rem_vec, add_vec, trip_vec, step_en;
  logic [CW-1:0]       rem_idx, add_idx, trip_idx;
  logic                rem_vld, add_vld, trip_vld;

  assign rem_vec  = en_q & ~tgt_q;
  assign add_vec  = tgt_q & ~en_q;
  assign trip_vec = heater_error & en_q;

  heater_prio_enc #(.W(Nchan), .FIND_HIGH(1'b1)) u_rem (
    .vec(rem_vec), .idx(rem_idx), .valid(rem_vld));
  heater_prio_enc #(.W(Nchan), .FIND_HIGH(1'b0)) u_add (
    .vec(add_vec), .idx(add_idx), .valid(add_vld));
  heater_prio_enc #(.W(Nchan), .FIND_HIGH(1'b0)) u_chan (
    .vec(trip_vec), .idx(trip_idx), .valid(trip_vld));

  // Removals outrank additions so the supply never sees both at once.
  always_comb begin
    if (rem_vld)      step_en = en_q & ~(ONE << rem_idx);
    else if (add_vld) step_en = en_q | (ONE << add_idx);
    else              step_en = en_q;
  end

  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    clr_d    = '0;
    mask_d   = mask_q;
    chan_d   = chan_q;
    timer_d  = timer_q;
    cnt_d    = cnt_q;
    sticky_d = clear_req ? heater_error : (sticky_q | heater_error);

    case (state_q)
      IDLE: begin
        en_d = '0;
        if (tgt_q != '0) begin
          state_d = STEP;
          timer_d = step_interval;
        end
      end
      STEP: begin
        if (timer_q == '0) begin
          en_d    = step_en;
          timer_d = step_interval;
          if (step_en == tgt_q) state_d = (tgt_q == '0) ? IDLE : STEADY;
        end else begin
          timer_d = timer_q - STEP_W'(1);
        end
      end
      STEADY: begin
        if (tgt_q != en_q) begin
          state_d = STEP;
          timer_d = step_interval;
        end
      end
      FAULT: begin
        en_d = '0;
        if (clear_req) begin
          state_d = CLEAR;
          clr_d   = mask_q;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        en_d = '0;
        // cnt reaches Nclr one cycle after the last clear pulse; judge recovery then.
        if (cnt_q == KW'(Nclr)) begin
          if ((heater_error & mask_q) != '0) begin
            state_d = FAULT;
          end else begin
            state_d = IDLE;
            mask_d  = '0;
            chan_d  = '0;
          end
        end else begin
          cnt_d = cnt_q + KW'(1);
          if (cnt_q < KW'(Nclr - 1)) clr_d = mask_q;
        end
      end
      default: state_d = IDLE;
    endcase

    if (fault_en && trip_vld && (state_q inside {IDLE, STEP, STEADY})) begin
      state_d = FAULT;
      en_d    = '0;
      mask_d  = trip_vec;
      chan_d  = trip_idx;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      tgt_q    <= '0;
      en_q     <= '0;
      clr_q    <= '0;
      mask_q   <= '0;
      chan_q   <= '0;
      sticky_q <= '0;
      timer_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      tgt_q    <= target_mask;
      en_q     <= en_d;
      clr_q    <= clr_d;
      mask_q   <= mask_d;
      chan_q   <= chan_d;
      sticky_q <= sticky_d;
      timer_q  <= timer_d;
      cnt_q    <= cnt_d;
    end
  end

  assign heater_enable    = en_q;
  assign heater_err_clear = clr_q;
  assign fault_mask       = mask_q;
  assign fault_chan       = chan_q;
  assign err_sticky       = sticky_q;
  assign busy             = state_q inside {STEP, FAULT, CLEAR};
  assign fault            = state_q inside {FAULT, CLEAR};
endmodule

// File: tb/tb_heater_ramp_ctrl.sv
// Directed bench for heater_ramp_ctrl: ramps, retarget, faults, recovery and reset.
module tb_heater_ramp_ctrl;
  logic        clk = 1'b0;
  logic        aresetn;
  logic [31:0] target_mask;
  logic [15:0] step_interval;
  logic        fault_en;
  logic        clear_req;
  logic [31:0] heater_error;
  logic [31:0] heater_enable;
  logic [31:0] heater_err_clear;
  logic        busy;
  logic        fault;
  logic [31:0] fault_mask;
  logic [4:0]  fault_chan;
  logic [31:0] err_sticky;

  int total = 0;
  int bad   = 0;
  logic [31:0] prev;
  logic [31:0] up_seq  [4] = '{32'h1, 32'h3, 32'h7, 32'hF};
  logic [31:0] ret_seq [6] = '{32'h7, 32'h3, 32'h1, 32'h0, 32'h10, 32'h30};
  logic [31:0] fast_seq[6] = '{32'h31, 32'h33, 32'h37, 32'h3F, 32'h7F, 32'hFF};

  heater_ramp_ctrl #(.Nchan(32), .Nclr(4)) dut (
    .clk(clk), .aresetn(aresetn), .target_mask(target_mask),
    .step_interval(step_interval), .fault_en(fault_en), .clear_req(clear_req),
    .heater_error(heater_error), .heater_enable(heater_enable),
    .heater_err_clear(heater_err_clear), .busy(busy), .fault(fault),
    .fault_mask(fault_mask), .fault_chan(fault_chan), .err_sticky(err_sticky));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    aresetn = 1'b0; target_mask = '0; step_interval = '0;
    fault_en = 1'b0; clear_req = 1'b0; heater_error = '0;
    tick();
    chk("rst_en", heater_enable, 0);
    chk("rst_clr", heater_err_clear, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fault", fault, 0);
    chk("rst_mask", fault_mask, 0);
    chk("rst_chan", fault_chan, 0);
    chk("rst_sticky", err_sticky, 0);
    tick();
    aresetn = 1'b1;
    tick();
    chk("idle_busy", busy, 0);

    // Ramp up to 0xF at 4-cycle spacing
    step_interval = 16'd3; target_mask = 32'hF;
    tick(); tick();
    chk("up_entry_busy", busy, 1);
    chk("up_entry_en", heater_enable, 0);
    prev = 32'h0;
    for (int k = 0; k < 4; k++) begin
      repeat (3) tick();
      chk("up_hold", heater_enable, prev);
      tick();
      chk("up_step", heater_enable, up_seq[k]);
      prev = up_seq[k];
    end
    chk("up_done_busy", busy, 0);

    // Retarget 0xF -> 0x30, removals first
    target_mask = 32'h30;
    tick(); tick();
    chk("ret_entry_busy", busy, 1);
    for (int k = 0; k < 6; k++) begin
      repeat (3) tick();
      chk("ret_hold", heater_enable, prev);
      tick();
      chk("ret_step", heater_enable, ret_seq[k]);
      prev = ret_seq[k];
    end
    chk("ret_done_busy", busy, 0);

    // step_interval=0: one channel per cycle
    step_interval = 16'd0; target_mask = 32'hFF;
    tick(); tick();
    chk("fast_entry_en", heater_enable, 32'h30);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("fast_step", heater_enable, fast_seq[k]);
    end
    chk("fast_done_busy", busy, 0);

    // fault_en=0: errors recorded, no trip
    fault_en = 1'b0; heater_error = 32'h1;
    tick();
    chk("fen0_en", heater_enable, 32'hFF);
    chk("fen0_fault", fault, 0);
    chk("fen0_sticky", err_sticky, 32'h1);

    // errors on disabled channels do not trip
    fault_en = 1'b1; heater_error = 32'hF00;
    tick();
    chk("dis_en", heater_enable, 32'hFF);
    chk("dis_fault", fault, 0);
    chk("dis_sticky", err_sticky, 32'hF01);

    // trip on channel 5
    heater_error = 32'h20;
    tick();
    chk("trip_en", heater_enable, 0);
    chk("trip_fault", fault, 1);
    chk("trip_busy", busy, 1);
    chk("trip_mask", fault_mask, 32'h20);
    chk("trip_chan", fault_chan, 5);
    chk("trip_sticky", err_sticky, 32'hF21);

    // fault_en=0 and target changes do not leave FAULT
    fault_en = 1'b0; target_mask = 32'h0F;
    tick(); tick(); tick();
    chk("hold_fault", fault, 1);
    chk("hold_en", heater_enable, 0);
    fault_en = 1'b1; target_mask = 32'hFF;
    tick(); tick();

    // recovery with error still present: back to FAULT
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    chk("clrh_pulse1", heater_err_clear, 32'h20);
    chk("clrh_sticky", err_sticky, 32'h20);
    tick(); tick(); tick();
    chk("clrh_pulse4", heater_err_clear, 32'h20);
    tick();
    chk("clrh_pulse_end", heater_err_clear, 0);
    tick();
    chk("clrh_fault", fault, 1);
    chk("clrh_mask", fault_mask, 32'h20);
    tick();
    chk("clrh_fault_stay", fault, 1);

    // recovery with error gone: IDLE then re-ramp to 0xFF
    heater_error = 32'h0;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    chk("clr_pulse1", heater_err_clear, 32'h20);
    chk("clr_sticky", err_sticky, 0);
    tick(); tick(); tick();
    chk("clr_pulse4", heater_err_clear, 32'h20);
    tick();
    chk("clr_pulse_end", heater_err_clear, 0);
    chk("clr_fault_s", fault, 1);
    tick();
    chk("clr_fault", fault, 0);
    chk("clr_busy", busy, 0);
    chk("clr_mask", fault_mask, 0);
    chk("clr_chan", fault_chan, 0);
    tick();
    chk("rer_busy", busy, 1);
    chk("rer_en0", heater_enable, 0);
    for (int k = 0; k < 8; k++) begin
      tick();
      prev = (32'h2 << k) - 32'h1;
      chk("rer_step", heater_enable, prev);
    end
    chk("rer_done_busy", busy, 0);

    // fault in the same cycle as a scheduled step
    step_interval = 16'd3; target_mask = 32'h0F;
    tick(); tick();
    chk("tie_entry_en", heater_enable, 32'hFF);
    tick(); tick(); tick();
    chk("tie_pre_en", heater_enable, 32'hFF);
    heater_error = 32'h06;
    tick();
    chk("tie_en", heater_enable, 0);
    chk("tie_fault", fault, 1);
    chk("tie_mask", fault_mask, 32'h06);
    chk("tie_chan", fault_chan, 1);

    // recover, start ramp to 0xF, then async reset mid-ramp
    heater_error = 32'h0;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (5) tick();
    chk("tie_rec_fault", fault, 0);
    tick();
    chk("mid_busy", busy, 1);
    repeat (4) tick();
    chk("mid_en", heater_enable, 32'h1);
    heater_error = 32'h100;
    tick();
    chk("mid_sticky", err_sticky, 32'h100);
    aresetn = 1'b0;
    #1;
    chk("arst_en", heater_enable, 0);
    chk("arst_busy", busy, 0);
    chk("arst_fault", fault, 0);
    chk("arst_sticky", err_sticky, 0);
    chk("arst_mask", fault_mask, 0);
    heater_error = 32'h0;
    tick();
    aresetn = 1'b1;
    tick();
    chk("post_busy", busy, 0);
    tick();
    chk("post_step_busy", busy, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/heater_ramp_ctrl.md
# heater_ramp_ctrl

Soft-start sequencer and fault supervisor for the heater array. It sits between the AXI register file and the `heater` instances. It takes a software target enable mask and changes the heater enables one channel at a time, at a programmable step interval, to limit supply inrush. It shuts every channel down on any error from an enabled heater, and sequences the err_clear pulse that recovers from the fault.

## Interface
Parameters:
- Nchan, 32, number of heater channels.
- Nclr, 4, err_clear pulse length in cycles (>=1).

Ports:
- clk  in  1  heater clock; the block uses only this clock.
- aresetn  in  1  reset, asynchronous and active-low.
- target_mask  in  Nchan  requested enables (register-file level).
- step_interval  in  16  wait between steps is step_interval+1 cycles.
- fault_en  in  1  1 = errors trip a shutdown; 0 = errors only recorded.
- clear_req  in  1  single-cycle pulse that starts fault recovery.
- heater_error  in  Nchan  error bits from the heater instances.
- heater_enable  out  Nchan  registered enables to the heaters.
- heater_err_clear  out  Nchan  registered clear pulses to the heaters.
- busy  out  1  high in STEP, FAULT or CLEAR.
- fault  out  1  high in FAULT and CLEAR.
- fault_mask  out  Nchan  enabled channels in error at the trip.
- fault_chan  out  $clog2(Nchan)  lowest index in fault_mask.
- err_sticky  out  Nchan  OR-accumulated heater_error; cleared by clear_req.

## Operation
- All outputs reset to 0, and the state resets to IDLE.
- target_mask is registered once internally as tgt; every decision uses tgt.
- IDLE: enable==0. Goes to STEP when tgt!=0.
- STEP: enable!=tgt. Timer is loaded with step_interval on entry and after each step, and decrements each cycle. At zero it performs exactly one step:
  - If some channel is enabled but not in tgt, clear the highest such bit. Removals have priority.
  - Otherwise set the lowest bit that is in tgt but not enabled.
  - When the step makes enable==tgt, go to STEADY, or to IDLE if tgt==0.
- STEADY: enable==tgt!=0. Any tgt change goes to STEP with the timer reloaded.
- Fault detection is active in IDLE, STEP and STEADY, when fault_en=1 and (heater_error & heater_enable)!=0:
  - Next cycle: enable=0, fault_mask is captured, fault_chan is set, state goes to FAULT.
  - A fault takes precedence over a step scheduled in the same cycle.
- FAULT: enables stay at 0, and tgt changes are held but not acted on. clear_req goes to CLEAR. Every other input is ignored.
- CLEAR:
  - heater_err_clear = fault_mask for Nclr cycles.
  - One cycle after that, sample heater_error & fault_mask:
    - If nonzero, go back to FAULT with fault_mask unchanged.
    - If zero, fault_mask and fault_chan go to 0 and the state goes to IDLE. The ramp then restarts from zero toward the current tgt.
- err_sticky:
  - Updated every cycle in all states.
  - A clear_req cycle sets err_sticky = heater_error; the OR with the old value is skipped for that cycle.
- clear_req outside FAULT only clears err_sticky.
- fault_en=0 while in FAULT does not exit FAULT.
- Errors on disabled channels never trip a fault; they only set err_sticky.

## Timing
- target_mask change to STEP entry: 2 cycles (input register, then state register).
- First enable change occurs step_interval+1 cycles after STEP entry; each later change follows the previous one by step_interval+1 cycles.
- step_interval=0 gives one channel change per cycle.
- Fault trip: heater_error asserted in cycle N gives heater_enable=0, fault=1 and state FAULT in cycle N+1.
- clear_req in cycle N: heater_err_clear is high in cycles N+1 through N+Nclr, and the result is sampled in cycle N+Nclr+1.
- A mid-operation aresetn assertion forces all outputs to 0 asynchronously.

## Structure
- Package heater_pkg holds:
  - the state enum (IDLE, STEP, STEADY, FAULT, CLEAR);
  - the default Nchan localparam;
  - the 16-bit step-interval width.
- Sub-module heater_prio_enc: parameterized lowest-set-bit and highest-set-bit encoder with a valid flag. It is instantiated three times:
  - lowest channel to add;
  - highest channel to remove;
  - fault_chan.

## Test plan
- Ramp up: step_interval=3, target 0x0000000F. heater_enable reads 0x1, 0x3, 0x7, 0xF at 4-cycle spacing; busy falls when 0xF is reached.
- Retarget: from 0xF, target changes to 0x30. Enable sequence is 0x7, 0x3, 0x1, 0x0, 0x10, 0x30, because removals come first.
- Fault: from STEADY 0xFF, heater_error=0x20. One cycle later enable=0, fault_mask=0x20, fault_chan=5.
  - Errors on bits 8 and up while disabled do not trip; they only set err_sticky.
- Recovery: clear_req in cycle N gives heater_err_clear=0x20 for cycles N+1 to N+4.
  - Error cleared: state IDLE, then a re-ramp to 0xFF.
  - Error held: the block returns to FAULT.
- Corner cases:
  - step_interval=0 gives a one-channel-per-cycle ramp.
  - A fault in the same cycle as a step tick: the fault wins.
  - fault_en=0 with errors: no trip.
  - aresetn asserted mid-ramp: all outputs read 0 immediately.
